// File: rtl/tick_count_writer.sv
// Emits one ASCII line per accepted timer tick: BCD message counter MSD first, then CR LF.
// Valid/ready byte stream; the counter advances once per completed line.
module tick_count_writer #(
  parameter int DIGITS    = 4,
  parameter int SEND_CRLF = 1
) (
  input  logic                  clki,
  input  logic                  rst,
  input  logic                  tick,
  output logic [7:0]            data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  busy,
  output logic                  overrun,
  output logic [4*DIGITS-1:0]   count_bcd
);

  localparam int             IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  IDX_TOP = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGIT,
    S_CR,
    S_LF,
    S_INCR
  } state_t;

  state_t               state;
  logic [4*DIGITS-1:0]  shadow;
  logic [4*DIGITS-1:0]  shadow_sh;
  logic [4*DIGITS-1:0]  count_inc;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic                 accept;

  assign accept = valid && ready;

  // The shadow is shifted left per accepted digit so the next digit is always the top nibble.
  assign shadow_sh = shadow << 4;

  always_comb begin
    count_inc = count_bcd;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_bcd[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clki) begin
    if (rst) begin
      state     <= S_IDLE;
      shadow    <= '0;
      idx       <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      count_bcd <= '0;
    end else begin
      overrun <= tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (tick) begin
            shadow <= count_bcd;
            idx    <= IDX_TOP;
            data   <= {4'h3, count_bcd[4*DIGITS-1 -: 4]};
            valid  <= 1'b1;
            busy   <= 1'b1;
            state  <= S_DIGIT;
          end
        end
        S_DIGIT: begin
          if (accept) begin
            if (idx == '0) begin
              if (SEND_CRLF != 0) begin
                data  <= 8'h0D;
                state <= S_CR;
              end else begin
                valid <= 1'b0;
                state <= S_INCR;
              end
            end else begin
              idx    <= idx - IW'(1);
              shadow <= shadow_sh;
              data   <= {4'h3, shadow_sh[4*DIGITS-1 -: 4]};
            end
          end
        end
        S_CR: begin
          if (accept) begin
            data  <= 8'h0A;
            state <= S_LF;
          end
        end
        S_LF: begin
          if (accept) begin
            valid <= 1'b0;
            state <= S_INCR;
          end
        end
        S_INCR: begin
          count_bcd <= count_inc;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
